// File: rtl/conv2_mac_sched.sv
// conv2_mac_sched
//
// Steps one shared 25-tap multiply-accumulate engine through every
// (input channel, filter) pair of a buffered 5x5x3 conv2 window. The engine
// is handed one pair per cycle. Its partial sums are accumulated across the
// channels of each filter. The result is emitted once per filter, scaled by
// 1/64 (arithmetic truncation). An end-of-frame strobe is raised on the last
// result of every WIN_PER_FRAME-th window.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   win_valid   window buffer holds a complete window (held stable until done)
//   win_ready   block is idle and can accept a window (combinational)
//   ch_sel      channel select to the shared engine
//   filt_sel    weight bank select to the shared engine
//   psum_in     signed partial sum from the engine for ch_sel/filt_sel
//   conv_out    scaled accumulated result, held between strobes
//   conv_filt   filter index belonging to conv_out
//   conv_valid  one-cycle strobe marking a new conv_out/conv_filt
//   busy        window in progress (registered)
//   frame_done  one-cycle strobe with the last result of a frame

module conv2_mac_sched #(
    parameter int NUM_CH        = 3,
    parameter int NUM_FILT      = 3,
    parameter int ACC_W         = 20,
    parameter int OUT_W         = 14,
    parameter int WIN_PER_FRAME = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    win_valid,
    output logic                    win_ready,
    output logic [1:0]              ch_sel,
    output logic [1:0]              filt_sel,
    input  logic signed [ACC_W-1:0] psum_in,
    output logic [OUT_W-1:0]        conv_out,
    output logic [1:0]              conv_filt,
    output logic                    conv_valid,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int CNT_W = (WIN_PER_FRAME > 1) ? $clog2(WIN_PER_FRAME) : 1;
    localparam logic [1:0]       LAST_CH   = 2'(NUM_CH - 1);
    localparam logic [1:0]       LAST_FILT = 2'(NUM_FILT - 1);
    localparam logic [CNT_W-1:0] LAST_WIN  = CNT_W'(WIN_PER_FRAME - 1);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t             state, state_next;
    logic [ACC_W-1:0]   acc, acc_next;
    logic [ACC_W-1:0]   acc_sum;
    logic [1:0]         ch_next, filt_next;
    logic [OUT_W-1:0]   out_next;
    logic [1:0]         cfilt_next;
    logic               valid_next;
    logic               fd_next;
    logic [CNT_W-1:0]   win_cnt, cnt_next;

    assign win_ready = (state == IDLE);

    // Two's complement sum that wraps silently on overflow.
    assign acc_sum = acc + psum_in;

    always_comb begin
        state_next = state;
        acc_next   = acc;
        ch_next    = ch_sel;
        filt_next  = filt_sel;
        out_next   = conv_out;
        cfilt_next = conv_filt;
        valid_next = 1'b0;
        fd_next    = 1'b0;
        cnt_next   = win_cnt;

        case (state)
            IDLE: begin
                ch_next   = 2'd0;
                filt_next = 2'd0;
                if (win_valid) begin
                    state_next = ACCUM;
                    acc_next   = '0;
                end
            end
            ACCUM: begin
                if (ch_sel != LAST_CH) begin
                    acc_next = acc_sum;
                    ch_next  = ch_sel + 2'd1;
                end else begin
                    // Top OUT_W bits of the sum: floor divide by 2^(ACC_W-OUT_W).
                    out_next   = acc_sum[ACC_W-1 -: OUT_W];
                    cfilt_next = filt_sel;
                    valid_next = 1'b1;
                    acc_next   = '0;
                    ch_next    = 2'd0;
                    if (filt_sel != LAST_FILT) begin
                        filt_next = filt_sel + 2'd1;
                    end else begin
                        filt_next  = 2'd0;
                        state_next = IDLE;
                        if (win_cnt == LAST_WIN) begin
                            cnt_next = '0;
                            fd_next  = 1'b1;
                        end else begin
                            cnt_next = win_cnt + 1'b1;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // busy is registered from the next state so it tracks state exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            ch_sel     <= 2'd0;
            filt_sel   <= 2'd0;
            conv_out   <= '0;
            conv_filt  <= 2'd0;
            conv_valid <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            win_cnt    <= '0;
        end else begin
            state      <= state_next;
            acc        <= acc_next;
            ch_sel     <= ch_next;
            filt_sel   <= filt_next;
            conv_out   <= out_next;
            conv_filt  <= cfilt_next;
            conv_valid <= valid_next;
            busy       <= (state_next == ACCUM);
            frame_done <= fd_next;
            win_cnt    <= cnt_next;
        end
    end

endmodule

// File: tb/tb_conv2_mac_sched.sv
// tb_conv2_mac_sched
//
// Directed self-checking bench for conv2_mac_sched. Inputs change and
// outputs are sampled on the falling clock edge. N0 is the falling edge right
// after the accept edge. At Nk (k=0..8) the block is in its (k+1)-th
// accumulate cycle with ch_sel=k%3 and filt_sel=k/3. Results appear at N3,
// N6 and N9, and the block is idle again at N9.

module tb_conv2_mac_sched;

    localparam int ACC_W = 20;
    localparam int OUT_W = 14;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b1;
    logic             win_valid = 1'b0;
    logic [ACC_W-1:0] psum_in   = '0;

    logic             win_ready;
    logic [1:0]       ch_sel;
    logic [1:0]       filt_sel;
    logic [OUT_W-1:0] conv_out;
    logic [1:0]       conv_filt;
    logic             conv_valid;
    logic             busy;
    logic             frame_done;

    int checks = 0;
    int errors = 0;

    conv2_mac_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .ch_sel     (ch_sel),
        .filt_sel   (filt_sel),
        .psum_in    (psum_in),
        .conv_out   (conv_out),
        .conv_filt  (conv_filt),
        .conv_valid (conv_valid),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Reset state observed while rst_n is low, before any clock edge.
    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (win_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_win_ready got %b expected 1", win_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
        checks++; if (conv_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_conv_valid got %b expected 0", conv_valid); end
        checks++; if (conv_out !== 14'h0000) begin errors++; $display("[TB] FAIL reset_conv_out got %h expected 0000", conv_out); end
        checks++; if (conv_filt !== 2'd0) begin errors++; $display("[TB] FAIL reset_conv_filt got %0d expected 0", conv_filt); end
        checks++; if (ch_sel !== 2'd0) begin errors++; $display("[TB] FAIL reset_ch_sel got %0d expected 0", ch_sel); end
        checks++; if (filt_sel !== 2'd0) begin errors++; $display("[TB] FAIL reset_filt_sel got %0d expected 0", filt_sel); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done got %b expected 0", frame_done); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // psum_in=64 every cycle: three results of 3, filters 0,1,2, ready low 9 cycles.
    task automatic test_basic();
        logic [1:0] exp_ch, exp_filt;
        logic       exp_ready, exp_busy, exp_valid;
        psum_in   = 20'd64;
        win_valid = 1'b1;
        @(negedge clk);
        win_valid = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) @(negedge clk);
            exp_ready = (k >= 9);
            exp_busy  = (k < 9);
            exp_valid = (k == 3 || k == 6 || k == 9);
            exp_ch    = (k < 9) ? 2'(k % 3) : 2'd0;
            exp_filt  = (k < 9) ? 2'(k / 3) : 2'd0;
            checks++; if (win_ready !== exp_ready) begin errors++; $display("[TB] FAIL basic_win_ready k=%0d got %b expected %b", k, win_ready, exp_ready); end
            checks++; if (busy !== exp_busy) begin errors++; $display("[TB] FAIL basic_busy k=%0d got %b expected %b", k, busy, exp_busy); end
            checks++; if (conv_valid !== exp_valid) begin errors++; $display("[TB] FAIL basic_conv_valid k=%0d got %b expected %b", k, conv_valid, exp_valid); end
            checks++; if (ch_sel !== exp_ch) begin errors++; $display("[TB] FAIL basic_ch_sel k=%0d got %0d expected %0d", k, ch_sel, exp_ch); end
            checks++; if (filt_sel !== exp_filt) begin errors++; $display("[TB] FAIL basic_filt_sel k=%0d got %0d expected %0d", k, filt_sel, exp_filt); end
            if (exp_valid) begin
                checks++; if (conv_filt !== 2'(k / 3 - 1)) begin errors++; $display("[TB] FAIL basic_conv_filt k=%0d got %0d expected %0d", k, conv_filt, k / 3 - 1); end
            end
            if (k >= 3) begin
                checks++; if (conv_out !== 14'h0003) begin errors++; $display("[TB] FAIL basic_conv_out k=%0d got %h expected 0003", k, conv_out); end
            end
        end
    endtask

    // Negative sums: -192 -> -3 and -3 -> floor(-3/64) = -1.
    task automatic test_negative();
        logic [ACC_W-1:0] vals [2];
        logic [OUT_W-1:0] exps [2];
        vals[0] = 20'hFFFC0;
        vals[1] = 20'hFFFFF;
        exps[0] = 14'h3FFD;
        exps[1] = 14'h3FFF;
        for (int v = 0; v < 2; v++) begin
            psum_in   = vals[v];
            win_valid = 1'b1;
            @(negedge clk);
            win_valid = 1'b0;
            for (int k = 1; k <= 9; k++) begin
                @(negedge clk);
                if (k % 3 == 0) begin
                    checks++; if (conv_valid !== 1'b1) begin errors++; $display("[TB] FAIL neg_conv_valid v=%0d k=%0d got %b expected 1", v, k, conv_valid); end
                    checks++; if (conv_out !== exps[v]) begin errors++; $display("[TB] FAIL neg_conv_out v=%0d k=%0d got %h expected %h", v, k, conv_out, exps[v]); end
                    checks++; if (conv_filt !== 2'(k / 3 - 1)) begin errors++; $display("[TB] FAIL neg_conv_filt v=%0d k=%0d got %0d expected %0d", v, k, conv_filt, k / 3 - 1); end
                end
            end
        end
    endtask

    // 7FFFF + 1 + 0 wraps to 80000 -> 2000; later filters must start from 0.
    task automatic test_wrap();
        psum_in   = 20'h00000;
        win_valid = 1'b1;
        @(negedge clk);
        win_valid = 1'b0;
        psum_in   = 20'h7FFFF;
        @(negedge clk);
        psum_in   = 20'h00001;
        @(negedge clk);
        psum_in   = 20'h00000;
        for (int k = 3; k <= 9; k++) begin
            @(negedge clk);
            if (k % 3 == 0) begin
                checks++; if (conv_valid !== 1'b1) begin errors++; $display("[TB] FAIL wrap_conv_valid k=%0d got %b expected 1", k, conv_valid); end
                checks++; if (conv_filt !== 2'(k / 3 - 1)) begin errors++; $display("[TB] FAIL wrap_conv_filt k=%0d got %0d expected %0d", k, conv_filt, k / 3 - 1); end
                checks++; if (conv_out !== ((k == 3) ? 14'h2000 : 14'h0000)) begin errors++; $display("[TB] FAIL wrap_conv_out k=%0d got %h expected %h", k, conv_out, (k == 3) ? 14'h2000 : 14'h0000); end
            end
        end
    endtask

    // win_valid held high: accepts at N-1, N9, N19; mid-window drop is ignored.
    task automatic test_back_to_back();
        int         strobes = 0;
        int         r;
        logic       in_win;
        logic [1:0] exp_ch, exp_filt;
        psum_in   = 20'd64;
        win_valid = 1'b1;
        @(negedge clk);
        for (int k = 0; k <= 30; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 25) win_valid = 1'b0;
            r        = k % 10;
            in_win   = (k < 30) && (r < 9);
            exp_ch   = in_win ? 2'(r % 3) : 2'd0;
            exp_filt = in_win ? 2'(r / 3) : 2'd0;
            if (conv_valid) strobes++;
            checks++; if (busy !== in_win) begin errors++; $display("[TB] FAIL b2b_busy k=%0d got %b expected %b", k, busy, in_win); end
            checks++; if (win_ready !== !in_win) begin errors++; $display("[TB] FAIL b2b_win_ready k=%0d got %b expected %b", k, win_ready, !in_win); end
            checks++; if (ch_sel !== exp_ch) begin errors++; $display("[TB] FAIL b2b_ch_sel k=%0d got %0d expected %0d", k, ch_sel, exp_ch); end
            checks++; if (filt_sel !== exp_filt) begin errors++; $display("[TB] FAIL b2b_filt_sel k=%0d got %0d expected %0d", k, filt_sel, exp_filt); end
        end
        checks++; if (strobes !== 9) begin errors++; $display("[TB] FAIL b2b_strobes got %0d expected 9", strobes); end
    endtask

    // Asynchronous reset at ch=1, filt=1 drops the window; next window starts clean.
    task automatic test_reset_mid();
        psum_in   = 20'd64;
        win_valid = 1'b1;
        @(negedge clk);
        win_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (ch_sel !== 2'd1) begin errors++; $display("[TB] FAIL rmid_pre_ch_sel got %0d expected 1", ch_sel); end
        checks++; if (filt_sel !== 2'd1) begin errors++; $display("[TB] FAIL rmid_pre_filt_sel got %0d expected 1", filt_sel); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (ch_sel !== 2'd0) begin errors++; $display("[TB] FAIL rmid_ch_sel got %0d expected 0", ch_sel); end
        checks++; if (filt_sel !== 2'd0) begin errors++; $display("[TB] FAIL rmid_filt_sel got %0d expected 0", filt_sel); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rmid_busy got %b expected 0", busy); end
        checks++; if (win_ready !== 1'b1) begin errors++; $display("[TB] FAIL rmid_win_ready got %b expected 1", win_ready); end
        checks++; if (conv_out !== 14'h0000) begin errors++; $display("[TB] FAIL rmid_conv_out got %h expected 0000", conv_out); end
        checks++; if (conv_filt !== 2'd0) begin errors++; $display("[TB] FAIL rmid_conv_filt got %0d expected 0", conv_filt); end
        checks++; if (conv_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_conv_valid got %b expected 0", conv_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++; if (conv_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_quiet_valid k=%0d got %b expected 0", k, conv_valid); end
            checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rmid_quiet_busy k=%0d got %b expected 0", k, busy); end
        end
        win_valid = 1'b1;
        @(negedge clk);
        win_valid = 1'b0;
        checks++; if (ch_sel !== 2'd0 || filt_sel !== 2'd0) begin errors++; $display("[TB] FAIL rmid_restart_sel got ch=%0d filt=%0d expected ch=0 filt=0", ch_sel, filt_sel); end
        repeat (3) @(negedge clk);
        checks++; if (conv_valid !== 1'b1) begin errors++; $display("[TB] FAIL rmid_first_valid got %b expected 1", conv_valid); end
        checks++; if (conv_filt !== 2'd0) begin errors++; $display("[TB] FAIL rmid_first_filt got %0d expected 0", conv_filt); end
        checks++; if (conv_out !== 14'h0003) begin errors++; $display("[TB] FAIL rmid_first_out got %h expected 0003", conv_out); end
        repeat (6) @(negedge clk);
    endtask

    // 65 back-to-back windows from a fresh counter: frame_done only on result 192.
    task automatic test_frame();
        int strobes   = 0;
        int fd_count  = 0;
        int fd_strobe = 0;
        int fd_alone  = 0;
        int s64       = 0;
        int fd64      = 0;
        #1;
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n     = 1'b1;
        psum_in   = 20'd64;
        win_valid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 650; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 640) win_valid = 1'b0;
            if (conv_valid) strobes++;
            if (frame_done) begin
                fd_count++;
                fd_strobe = strobes;
                if (!conv_valid) fd_alone++;
            end
            if (k == 639) begin
                s64  = strobes;
                fd64 = fd_count;
                checks++; if (frame_done !== 1'b1) begin errors++; $display("[TB] FAIL frame_done_at_last got %b expected 1", frame_done); end
            end
        end
        checks++; if (s64 !== 192) begin errors++; $display("[TB] FAIL frame_strobes64 got %0d expected 192", s64); end
        checks++; if (fd64 !== 1) begin errors++; $display("[TB] FAIL frame_done_count64 got %0d expected 1", fd64); end
        checks++; if (fd_strobe !== 192) begin errors++; $display("[TB] FAIL frame_done_strobe got %0d expected 192", fd_strobe); end
        checks++; if (fd_count !== 1) begin errors++; $display("[TB] FAIL frame_done_count65 got %0d expected 1", fd_count); end
        checks++; if (strobes !== 195) begin errors++; $display("[TB] FAIL frame_strobes65 got %0d expected 195", strobes); end
        checks++; if (fd_alone !== 0) begin errors++; $display("[TB] FAIL frame_done_alone got %0d expected 0", fd_alone); end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_negative();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv2_mac_sched.md
Name: conv2_mac_sched

Overview:
- Time-multiplexed sequencer for the second convolution layer's 25-tap signed multiply-accumulate sum engine.
- One shared engine computes the partial sum for one (input channel, filter) pair per cycle. This block accepts a buffered 5x5x3 window and steps the engine through every channel and filter.
- Accumulates the channel partial sums per filter and emits one scaled 14-bit result per filter.
- Sits between the conv2 window buffer and the conv2 ReLU/max-pool stage; also flags end of frame.

Parameters:
- NUM_CH, 3, input channels summed per output value
- NUM_FILT, 3, output filters computed per window
- ACC_W, 20, accumulator / partial-sum width (signed)
- OUT_W, 14, output width; output = acc[ACC_W-1 : ACC_W-OUT_W]
- WIN_PER_FRAME, 64, windows per image (8x8 conv2 outputs)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- win_valid  in  1  window buffer holds a complete window; data held stable until accepted
- win_ready  out  1  block can accept a window
- ch_sel  out  2  channel select to shared engine (0..NUM_CH-1)
- filt_sel  out  2  weight bank select to shared engine (0..NUM_FILT-1)
- psum_in  in  ACC_W  signed partial sum from engine for current ch_sel/filt_sel (combinational, same cycle)
- conv_out  out  OUT_W  scaled accumulated result
- conv_filt  out  2  filter index of conv_out
- conv_valid  out  1  one-cycle strobe, conv_out/conv_filt valid
- busy  out  1  window in progress
- frame_done  out  1  one-cycle strobe with the last result of the WIN_PER_FRAME-th window

Behaviour:
- Reset (asynchronous, rst_n=0) forces these to 0 immediately: state=IDLE, ch_sel, filt_sel, acc, conv_out, conv_filt, conv_valid, busy, frame_done, window counter.
- States: IDLE, ACCUM.
- win_ready = (state==IDLE), combinational. busy = (state==ACCUM), registered.
- IDLE:
  - ch_sel=0 and filt_sel=0.
  - win_valid&&win_ready -> ACCUM, acc=0.
  - Upstream holds window data until the window completes; busy signals this.
- ACCUM, each cycle:
  - acc_next = acc + psum_in, ACC_W-bit two's complement, wraps, no saturation.
  - If ch_sel < NUM_CH-1: acc<=acc_next; ch_sel++.
  - If ch_sel == NUM_CH-1:
    - conv_out<=acc_next[ACC_W-1:ACC_W-OUT_W] (arithmetic truncation, i.e. floor divide by 64).
    - conv_filt<=filt_sel; conv_valid<=1 for the next cycle only.
    - acc<=0; ch_sel<=0.
    - If filt_sel < NUM_FILT-1: filt_sel++, stay in ACCUM.
    - Else: filt_sel<=0, state<=IDLE.
- Latency and throughput:
  - NUM_CH*NUM_FILT ACCUM cycles per window; conv_valid follows ACCUM cycles 3, 6 and 9 after the accept edge.
  - Minimum 10 cycles per window: a one-cycle IDLE gap between windows.
- conv_out holds its value between strobes. conv_valid has no back-pressure; the downstream stage must accept every strobe.
- Window counter:
  - Increments at each window completion (last filter's final channel).
  - On the WIN_PER_FRAME-th completion: frame_done pulses together with that window's last conv_valid, and the counter wraps to 0.
- win_valid deasserting mid-window is ignored; the window completes.
- Reset mid-window drops the window: no conv_valid for it, the window counter restarts at 0, and the next accept starts at ch=0, filt=0.

Test Plan:
- psum_in=64 every cycle, one window -> three conv_valid strobes 3 cycles apart with conv_filt=0,1,2, conv_out=3 each; win_ready low for 9 cycles then high.
- psum_in=-64 every cycle -> conv_out=14'h3FFD (-3) on all three strobes; psum_in=-1 every cycle -> conv_out=14'h3FFF (floor of -3/64).
- Wrap: psum_in sequence 20'h7FFFF, 20'h00001, 20'h00000 for filter 0 -> acc 20'h80000, conv_out=14'h2000.
- win_valid held high continuously for 3 windows -> accepts at cycles 0, 10, 20; ch_sel sequence 0,1,2 repeating; filt_sel steps once every 3 cycles.
- rst_n pulsed low while ch_sel=1, filt_sel=1 -> all outputs 0 without waiting for a clock edge; no conv_valid until a new window is accepted; the first result after that has conv_filt=0.
- 64 windows, psum_in=64 -> 192 conv_valid strobes; frame_done exactly once, coincident with the 192nd; window 65 completion produces no frame_done.
